fwd_hazard_unit: RTL and testbench

- Tracks destination-register and control state of the instructions in EX, MEM and WB.
- Generates registered 2-bit forwarding selects for the two EX-stage operand muxes (00 = register file, 01 = MEM/WB writeback data, 10 = EX/MEM ALU result).
- Detects load-use hazards and issues a one-cycle stall with bubble insertion.
- Sits between ID decode and the ID/EX pipeline register; its outputs drive the operand forwarding muxes and the PC / IF/ID hold enables.

---
 rtl/fwd_hazard_unit.sv | 105 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select generation and load-use hazard detection for a 5-stage pipeline.
// Optional RF_BYPASS_EN adds combinational WB->ID bypass selects for register files without write-through.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
`ifdef RF_BYPASS_EN
  ,
  output logic              id_bypass_a,
  output logic              id_bypass_b
`endif
);

  logic [REG_AW-1:0] idex_rd;
  logic              idex_reg_write;
  logic              idex_mem_read;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_reg_write;

  logic [1:0]        fwd_a_next;
  logic [1:0]        fwd_b_next;
  logic              bubble;

  // Most recent producer wins: the instruction now in EX will be in MEM when the reader is in EX.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] ex_rd,
                                         input logic              ex_we,
                                         input logic [REG_AW-1:0] mem_rd,
                                         input logic              mem_we);
    if (ex_we && (ex_rd != '0) && (ex_rd == src))
      return 2'b10;
    else if (mem_we && (mem_rd != '0) && (mem_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    stall = 1'b0;
    if (!flush && idex_mem_read && (idex_rd != '0))
      stall = (idex_rd == id_rs) || (id_uses_rt && (idex_rd == id_rt));
    bubble     = stall || flush;
    fwd_a_next = fwd_sel(id_rs, idex_rd, idex_reg_write, exmem_rd, exmem_reg_write);
    fwd_b_next = fwd_sel(id_rt, idex_rd, idex_reg_write, exmem_rd, exmem_reg_write);
  end

`ifdef RF_BYPASS_EN
  always_comb begin
    id_bypass_a = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs);
    id_bypass_b = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rt);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_rd         <= '0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      exmem_rd        <= '0;
      exmem_reg_write <= 1'b0;
      memwb_rd        <= '0;
      memwb_reg_write <= 1'b0;
      forward_a       <= 2'b00;
      forward_b       <= 2'b00;
      stall_count     <= '0;
    end else begin
      if (bubble) begin
        idex_rd        <= '0;
        idex_reg_write <= 1'b0;
        idex_mem_read  <= 1'b0;
        forward_a      <= 2'b00;
        forward_b      <= 2'b00;
      end else begin
        idex_rd        <= id_rd;
        idex_reg_write <= id_reg_write;
        idex_mem_read  <= id_mem_read;
        forward_a      <= fwd_a_next;
        forward_b      <= fwd_b_next;
      end
      // Later stages always advance; a stall only holds PC and IF/ID.
      exmem_rd        <= idex_rd;
      exmem_reg_write <= idex_reg_write;
      memwb_rd        <= exmem_rd;
      memwb_reg_write <= exmem_reg_write;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit; a second instance with a narrow counter covers saturation.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt, id_reg_write, id_mem_read, flush;

  logic [1:0]  forward_a, forward_b;
  logic        stall;
  logic [15:0] stall_count;

  logic [1:0]  forward_a_s, forward_b_s;
  logic        stall_s;
  logic [2:0]  stall_count_s;

`ifdef RF_BYPASS_EN
  logic        id_bypass_a, id_bypass_b, id_bypass_a_s, id_bypass_b_s;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .stall_count(stall_count)
`ifdef RF_BYPASS_EN
    , .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b)
`endif
  );

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .forward_a(forward_a_s), .forward_b(forward_b_s), .stall(stall_s),
    .stall_count(stall_count_s)
`ifdef RF_BYPASS_EN
    , .id_bypass_a(id_bypass_a_s), .id_bypass_b(id_bypass_b_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an ID instruction and let the combinational stall settle.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic [4:0] rd, input logic we, input logic mr, input logic fl);
    id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_rd = rd;
    id_reg_write = we; id_mem_read = mr; flush = fl;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset_fa", forward_a, 0);
    check("reset_fb", forward_b, 0);
    check("reset_stall", stall, 0);
    check("reset_cnt", stall_count, 0);

    // EX->EX: add r3,r1,r2 then reader rs=3 rt=4
    drive(1, 2, 1, 3, 1, 0, 0); tick();
    drive(3, 4, 1, 6, 1, 0, 0);
    check("exex_stall", stall, 0);
    tick();
    check("exex_fa", forward_a, 2'b10);
    check("exex_fb", forward_b, 2'b00);

    // MEM->EX: writer r5, unrelated, reader rs=5
    drive(0, 0, 0, 5, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(5, 0, 1, 0, 0, 0, 0); tick();
    check("memex_fa", forward_a, 2'b01);
    check("memex_fb", forward_b, 2'b00);

    // Priority: two writers of r5, then reader
    drive(0, 0, 0, 5, 1, 0, 0); tick();
    drive(0, 0, 0, 5, 1, 0, 0); tick();
    drive(5, 0, 1, 0, 0, 0, 0); tick();
    check("prio_fa", forward_a, 2'b10);

    // r0 is never forwarded, even with writers in both later stages
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0, 0); tick();
    check("r0_fa", forward_a, 2'b00);
    check("r0_fb", forward_b, 2'b00);

    // Load-use on r7 via rt
    drive(0, 0, 0, 7, 1, 1, 0);
    check("lu_load_stall", stall, 0);
    tick();
    drive(1, 7, 1, 8, 1, 0, 0);
    check("lu_stall", stall, 1);
    check("lu_cnt_before", stall_count, 0);
    tick();
    check("lu_bubble_fa", forward_a, 2'b00);
    check("lu_bubble_fb", forward_b, 2'b00);
    check("lu_cnt_after", stall_count, 1);
    check("lu_stall_one_cycle", stall, 0);
    tick();
    check("lu_fb_mem", forward_b, 2'b01);
    check("lu_fa_mem", forward_a, 2'b00);
    check("lu_cnt_hold", stall_count, 1);

    // Same sequence without rt use: no stall, forward_b still computed
    drive(0, 0, 0, 7, 1, 1, 0); tick();
    drive(1, 7, 0, 8, 1, 0, 0);
    check("nouse_stall", stall, 0);
    tick();
    check("nouse_fb", forward_b, 2'b10);
    check("nouse_cnt", stall_count, 1);

    // Flush beats stall
    drive(0, 0, 0, 7, 1, 1, 0); tick();
    drive(7, 7, 1, 8, 1, 0, 1);
    check("flush_stall", stall, 0);
    tick();
    check("flush_fa", forward_a, 2'b00);
    check("flush_fb", forward_b, 2'b00);
    check("flush_cnt", stall_count, 1);
    // The flushed load-use reader left a bubble, so nothing follows into EX
    drive(8, 0, 0, 0, 0, 0, 0); tick();
    check("flush_bubble_fa", forward_a, 2'b00);

    // Reset during a stall cycle
    drive(0, 0, 0, 7, 1, 1, 0); tick();
    drive(7, 7, 1, 0, 0, 0, 0);
    check("rst_pre_stall", stall, 1);
    reset = 1'b1;
    tick();
    check("rst_stall", stall, 0);
    check("rst_fa", forward_a, 0);
    check("rst_fb", forward_b, 0);
    check("rst_cnt", stall_count, 0);
    reset = 1'b0;

    // Saturation on the 3-bit counter instance; 16-bit instance keeps counting
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 7, 1, 1, 0); tick();
      drive(0, 7, 1, 0, 0, 0, 0);
      check("sat_stall", stall, 1);
      tick();
      if (i == 6) check("sat_cnt_reach", stall_count_s, 3'd7);
    end
    check("sat_cnt_hold", stall_count_s, 3'd7);
    check("sat_main_cnt", stall_count, 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
